// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the instruction-memory address, registers the returned word
// for decode, resolves unconditional JMP locally and accepts taken-branch redirects.
module instruction_fetch_unit #(
  parameter int unsigned      PC_W     = 8,
  parameter int unsigned      INS_W    = 24,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [INS_W-1:0] NOP_INS  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic [INS_W-1:0] imem_data,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_rd_en,
  output logic [INS_W-1:0] ins,
  output logic [PC_W-1:0]  pc_dec,
  output logic             ins_valid
);

  localparam int unsigned OPC_W   = 5;
  localparam int unsigned OPC_MSB = INS_W - 1;
  localparam int unsigned OPC_LSB = INS_W - OPC_W;
  localparam int unsigned TGT_MSB = OPC_LSB - 1;
  localparam logic [OPC_W-1:0] JMP_OPC = 5'b11000;

  // FILL: no live word returning from memory; RUN: imem_data carries pc_m.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PC_W-1:0]  r_pc_f;
  logic [PC_W-1:0]  r_pc_m;
  logic [INS_W-1:0] r_ins;
  logic [PC_W-1:0]  r_pc_dec;
  logic             r_ins_valid;

  logic [PC_W-1:0]  w_pc_f_nxt;
  logic [PC_W-1:0]  w_pc_m_nxt;
  logic [INS_W-1:0] w_ins_nxt;
  logic [PC_W-1:0]  w_pc_dec_nxt;
  logic             w_ins_valid_nxt;
  logic             w_is_jmp;
  logic [PC_W-1:0]  w_jmp_target;
  logic [PC_W-1:0]  w_pc_seq;

  assign w_is_jmp     = (r_state == ST_RUN) && !stall && !br_taken &&
                        (imem_data[OPC_MSB:OPC_LSB] == JMP_OPC);
  assign w_jmp_target = imem_data[TGT_MSB -: PC_W];
  assign w_pc_seq     = r_pc_f + PC_W'(1);

  // State register and fetch/decode pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_FILL;
      r_pc_f      <= RESET_PC;
      r_pc_m      <= '0;
      r_ins       <= NOP_INS;
      r_pc_dec    <= '0;
      r_ins_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc_f      <= w_pc_f_nxt;
      r_pc_m      <= w_pc_m_nxt;
      r_ins       <= w_ins_nxt;
      r_pc_dec    <= w_pc_dec_nxt;
      r_ins_valid <= w_ins_valid_nxt;
    end
  end

  // Next-state: redirect beats stall, stall beats JMP, JMP beats sequential fetch.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_f_nxt      = r_pc_f;
    w_pc_m_nxt      = r_pc_m;
    w_ins_nxt       = r_ins;
    w_pc_dec_nxt    = r_pc_dec;
    w_ins_valid_nxt = r_ins_valid;

    if (br_taken) begin
      w_pc_f_nxt      = br_target;
      w_state_nxt     = ST_FILL;
      w_ins_nxt       = NOP_INS;
      w_ins_valid_nxt = 1'b0;
    end else if (!stall) begin
      w_pc_m_nxt = r_pc_f;
      case (r_state)
        ST_RUN: begin
          w_ins_nxt       = imem_data;
          w_pc_dec_nxt    = r_pc_m;
          w_ins_valid_nxt = 1'b1;
        end
        default: begin
          w_ins_nxt       = NOP_INS;
          w_ins_valid_nxt = 1'b0;
        end
      endcase
      // A JMP squashes the word already in flight at pc_m+1.
      if (w_is_jmp) begin
        w_pc_f_nxt  = w_jmp_target;
        w_state_nxt = ST_FILL;
      end else begin
        w_pc_f_nxt  = w_pc_seq;
        w_state_nxt = ST_RUN;
      end
    end
  end

  assign imem_addr  = r_pc_f;
  assign imem_rd_en = !stall || br_taken;
  assign ins        = r_ins;
  assign pc_dec     = r_pc_dec;
  assign ins_valid  = r_ins_valid;

endmodule
